// File: rtl/instr_queue_if.sv
// rtl/instr_queue_if.sv - fetch/issue handshake bundle for the instruction queue
interface instr_queue_if;
  logic        rdy;
  logic        clear_flag_in;
  logic        if_fetch_enable_out;
  logic        if_result_enable_in;
  logic [31:0] if_instr_in;
  logic [31:0] if_pc_in;
  logic        if_write_pc_sig_out;
  logic [31:0] if_write_pc_val_out;
  logic        issue_ready_in;
  logic        issue_valid_out;
  logic [31:0] issue_instr_out;
  logic [31:0] issue_pc_out;
  logic        issue_pred_jump_out;

  modport slave (
    input  rdy, clear_flag_in, if_result_enable_in, if_instr_in, if_pc_in, issue_ready_in,
    output if_fetch_enable_out, if_write_pc_sig_out, if_write_pc_val_out,
           issue_valid_out, issue_instr_out, issue_pc_out, issue_pred_jump_out
  );

  modport master (
    output rdy, clear_flag_in, if_result_enable_in, if_instr_in, if_pc_in, issue_ready_in,
    input  if_fetch_enable_out, if_write_pc_sig_out, if_write_pc_val_out,
           issue_valid_out, issue_instr_out, issue_pc_out, issue_pred_jump_out
  );
endinterface

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - instruction fetch queue with JAL next-pc prediction
module instr_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst,
  instr_queue_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] FETCH_LIMIT = DEPTH_CNT - 1'b1;

  logic [31:0]           r_instr_mem [DEPTH];
  logic [31:0]           r_pc_mem    [DEPTH];
  logic                  r_pred_mem  [DEPTH];
  logic [DEPTH_LOG2-1:0] r_head;
  logic [DEPTH_LOG2-1:0] r_tail;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_pending;
  logic                  r_drop;
  logic                  r_fetch_en;
  logic                  r_wpc_sig;
  logic [31:0]           r_wpc_val;

  logic        w_is_jal;
  logic [31:0] w_jal_imm;
  logic [31:0] w_next_pc;
  logic        w_valid;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_fetch_req;

  assign w_is_jal  = (bus.if_instr_in[6:0] == 7'b1101111);
  assign w_jal_imm = {{11{bus.if_instr_in[31]}}, bus.if_instr_in[31], bus.if_instr_in[19:12],
                      bus.if_instr_in[20], bus.if_instr_in[30:21], 1'b0};
  assign w_next_pc = bus.if_pc_in + (w_is_jal ? w_jal_imm : 32'd4);

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == DEPTH_CNT);
  assign w_pop   = w_valid && bus.issue_ready_in && !bus.clear_flag_in;
  assign w_push  = bus.if_result_enable_in && !r_drop && !bus.clear_flag_in && (!w_full || w_pop);

  // One request in flight, and never while the fetcher pc is still being redirected.
  assign w_fetch_req = !r_pending && !r_fetch_en && !r_wpc_sig && !r_drop &&
                       !bus.clear_flag_in && (r_count < FETCH_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst && bus.rdy && w_push) begin
      r_instr_mem[r_tail] <= bus.if_instr_in;
      r_pc_mem[r_tail]    <= bus.if_pc_in;
      r_pred_mem[r_tail]  <= w_is_jal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_pending  <= 1'b0;
      r_drop     <= 1'b0;
      r_fetch_en <= 1'b0;
      r_wpc_sig  <= 1'b0;
      r_wpc_val  <= '0;
    end else if (bus.rdy) begin
      if (bus.clear_flag_in) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_fetch_en <= 1'b0;
        r_wpc_sig  <= 1'b0;
        r_wpc_val  <= '0;
        // A request still in flight will return a stale instruction; swallow it.
        r_pending  <= r_fetch_en || (r_pending && !bus.if_result_enable_in);
        r_drop     <= r_fetch_en || (r_pending && !bus.if_result_enable_in) ||
                      (r_drop && !bus.if_result_enable_in);
      end else begin
        r_fetch_en <= w_fetch_req;
        r_wpc_sig  <= w_push;
        r_wpc_val  <= w_push ? w_next_pc : 32'd0;
        if (r_fetch_en)
          r_pending <= 1'b1;
        else if (bus.if_result_enable_in)
          r_pending <= 1'b0;
        if (bus.if_result_enable_in)
          r_drop <= 1'b0;
        if (w_push)
          r_tail <= r_tail + 1'b1;
        if (w_pop)
          r_head <= r_head + 1'b1;
        if (w_push && !w_pop)
          r_count <= r_count + 1'b1;
        else if (w_pop && !w_push)
          r_count <= r_count - 1'b1;
      end
    end
  end

  assign bus.if_fetch_enable_out = r_fetch_en;
  assign bus.if_write_pc_sig_out = r_wpc_sig;
  assign bus.if_write_pc_val_out = r_wpc_val;
  assign bus.issue_valid_out     = w_valid;
  assign bus.issue_instr_out     = r_instr_mem[r_head];
  assign bus.issue_pc_out        = r_pc_mem[r_head];
  assign bus.issue_pred_jump_out = r_pred_mem[r_head];
endmodule
